pfd_tdc_lock: RTL and testbench

//  Clocked phase-frequency detector for the PLL2 loop: samples ref (link) and vco, measures edge-to-edge

---
 rtl/pfd_tdc_lock_if.sv | 37 +++
 rtl/pfd_tdc_lock.sv | 188 ++++++++++++++++++
 tb/tb_pfd_tdc_lock.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pfd_tdc_lock_if.sv
// pfd_tdc_lock_if: signal bundle for the PLL2 clocked phase-frequency detector.
//   en        measurement enable          (master -> slave)
//   link      reference clock, async      (master -> slave)
//   vco       VCO feedback clock, async   (master -> slave)
//   up/dn     charge-pump pulses          (slave -> master)
//   upb/dnb   complements of up/dn        (slave -> master)
//   setting   {dn, up|dn}                 (slave -> master)
//   phase_err signed edge-to-edge error   (slave -> master)
//   err_valid phase_err update strobe     (slave -> master)
//   slip      cycle-slip strobe           (slave -> master)
//   lock      lock indicator              (slave -> master)
interface pfd_tdc_lock_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             link;
    logic             vco;
    logic             up;
    logic             dn;
    logic             upb;
    logic             dnb;
    logic [1:0]       setting;
    logic [CNT_W-1:0] phase_err;
    logic             err_valid;
    logic             slip;
    logic             lock;

    modport master (
        output en, link, vco,
        input  up, dn, upb, dnb, setting, phase_err, err_valid, slip, lock
    );

    modport slave (
        input  en, link, vco,
        output up, dn, upb, dnb, setting, phase_err, err_valid, slip, lock
    );
endinterface

// File: rtl/pfd_tdc_lock.sv
// pfd_tdc_lock: clocked phase-frequency detector / time-to-digital converter.
// Synchronises link (ref) and vco, measures the clk-cycle distance between
// their rising edges as a signed error, drives min-width up/dn pump pulses,
// flags cycle slips and declares lock after LOCK_CNT good measurements.
//   clk     sampling clock (much faster than link/vco)
//   fv_rst  asynchronous active-high reset
//   bus     pfd_tdc_lock_if.slave: en/link/vco in; up/dn/upb/dnb/setting/
//           phase_err/err_valid/slip/lock out
module pfd_tdc_lock #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PW      = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 4
) (
    input  logic          clk,
    input  logic          fv_rst,
    pfd_tdc_lock_if.slave bus
);
    localparam int CW = CNT_W - 1;
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int AW = $clog2(MIN_PW + 1);
    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [LW-1:0]    LCNT_MAX = LW'(LOCK_CNT);
    localparam logic [AW-1:0]    PW       = AW'(MIN_PW);
    localparam logic [CNT_W-1:0] TOL      = CNT_W'(LOCK_TOL);

    typedef enum logic [1:0] {IDLE = 2'd0, UP_RUN = 2'd1, DN_RUN = 2'd2} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync_l, r_sync_v;
    logic                   r_l_d, r_v_d;
    logic [CW-1:0]          r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [LW-1:0]          r_lcnt, w_lcnt_nxt;
    logic [CNT_W-1:0]       r_phase_err, w_phase_nxt, w_abs_err;
    logic                   r_err_valid, w_ev_nxt;
    logic                   r_slip, w_slip_nxt;
    logic                   r_up, r_dn, w_up_nxt, w_dn_nxt;
    logic [AW-1:0]          r_up_age, r_dn_age, w_up_age_nxt, w_dn_age_nxt;
    logic                   w_up_start, w_dn_start;
    logic                   w_re, w_ve;

    assign w_re      = r_sync_l[SYNC_STAGES-1] & ~r_l_d;
    assign w_ve      = r_sync_v[SYNC_STAGES-1] & ~r_v_d;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_abs_err = r_phase_err[CNT_W-1] ? (~r_phase_err + 1'b1) : r_phase_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_phase_nxt  = r_phase_err;
        w_ev_nxt     = 1'b0;
        w_slip_nxt   = 1'b0;
        w_up_start   = 1'b0;
        w_dn_start   = 1'b0;
        w_lcnt_nxt   = r_lcnt;
        w_up_nxt     = 1'b0;
        w_dn_nxt     = 1'b0;
        w_up_age_nxt = '0;
        w_dn_age_nxt = '0;

        case (r_state)
            IDLE: begin
                if (w_re && w_ve) begin
                    w_phase_nxt = '0;
                    w_ev_nxt    = 1'b1;
                    w_up_start  = 1'b1;
                    w_dn_start  = 1'b1;
                end else if (w_re) begin
                    w_state_nxt = UP_RUN;
                    w_cnt_nxt   = CW'(1);
                    w_up_start  = 1'b1;
                end else if (w_ve) begin
                    w_state_nxt = DN_RUN;
                    w_cnt_nxt   = CW'(1);
                    w_dn_start  = 1'b1;
                end
            end
            UP_RUN: begin
                if (w_ve) begin
                    w_phase_nxt = {1'b0, r_cnt};
                    w_ev_nxt    = 1'b1;
                    w_slip_nxt  = w_re;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    // A repeated leader edge is a slip, but time keeps running
                    // from the first leader edge.
                    w_slip_nxt = w_re;
                    w_cnt_nxt  = w_cnt_inc;
                end
            end
            DN_RUN: begin
                if (w_re) begin
                    w_phase_nxt = CNT_W'(0) - {1'b0, r_cnt};
                    w_ev_nxt    = 1'b1;
                    w_slip_nxt  = w_ve;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_slip_nxt = w_ve;
                    w_cnt_nxt  = w_cnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Pump outputs stay high while running, then until MIN_PW cycles have
        // elapsed since the most recent start; a restart reloads the age.
        w_up_nxt = w_up_start | (r_up & ((w_state_nxt == UP_RUN) | (r_up_age < PW)));
        w_dn_nxt = w_dn_start | (r_dn & ((w_state_nxt == DN_RUN) | (r_dn_age < PW)));
        if (w_up_start)
            w_up_age_nxt = AW'(1);
        else if (w_up_nxt)
            w_up_age_nxt = (r_up_age == PW) ? r_up_age : r_up_age + 1'b1;
        if (w_dn_start)
            w_dn_age_nxt = AW'(1);
        else if (w_dn_nxt)
            w_dn_age_nxt = (r_dn_age == PW) ? r_dn_age : r_dn_age + 1'b1;

        // Lock counter judges the registered measurement, one cycle behind.
        if (r_slip)
            w_lcnt_nxt = '0;
        else if (r_err_valid) begin
            if (w_abs_err <= TOL)
                w_lcnt_nxt = (r_lcnt == LCNT_MAX) ? r_lcnt : r_lcnt + 1'b1;
            else
                w_lcnt_nxt = '0;
        end

        if (!bus.en) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_phase_nxt  = r_phase_err;
            w_ev_nxt     = 1'b0;
            w_slip_nxt   = 1'b0;
            w_lcnt_nxt   = '0;
            w_up_nxt     = 1'b0;
            w_dn_nxt     = 1'b0;
            w_up_age_nxt = '0;
            w_dn_age_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge fv_rst) begin
        if (fv_rst) begin
            r_state     <= IDLE;
            r_sync_l    <= '0;
            r_sync_v    <= '0;
            r_l_d       <= 1'b0;
            r_v_d       <= 1'b0;
            r_cnt       <= '0;
            r_lcnt      <= '0;
            r_phase_err <= '0;
            r_err_valid <= 1'b0;
            r_slip      <= 1'b0;
            r_up        <= 1'b0;
            r_dn        <= 1'b0;
            r_up_age    <= '0;
            r_dn_age    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync_l    <= {r_sync_l[SYNC_STAGES-2:0], bus.link};
            r_sync_v    <= {r_sync_v[SYNC_STAGES-2:0], bus.vco};
            r_l_d       <= r_sync_l[SYNC_STAGES-1];
            r_v_d       <= r_sync_v[SYNC_STAGES-1];
            r_cnt       <= w_cnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_phase_err <= w_phase_nxt;
            r_err_valid <= w_ev_nxt;
            r_slip      <= w_slip_nxt;
            r_up        <= w_up_nxt;
            r_dn        <= w_dn_nxt;
            r_up_age    <= w_up_age_nxt;
            r_dn_age    <= w_dn_age_nxt;
        end
    end

    assign bus.up        = r_up;
    assign bus.dn        = r_dn;
    assign bus.upb       = ~r_up;
    assign bus.dnb       = ~r_dn;
    assign bus.setting   = {r_dn, r_up | r_dn};
    assign bus.phase_err = r_phase_err;
    assign bus.err_valid = r_err_valid;
    assign bus.slip      = r_slip;
    assign bus.lock      = (r_lcnt == LCNT_MAX);
endmodule

// File: tb/tb_pfd_tdc_lock.sv
module tb_pfd_tdc_lock;
    logic clk = 1'b0;
    logic fv_rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    pfd_tdc_lock_if #(.CNT_W(8)) bus ();

    pfd_tdc_lock #(
        .CNT_W(8), .SYNC_STAGES(2), .MIN_PW(2), .LOCK_TOL(1), .LOCK_CNT(4)
    ) dut (
        .clk(clk),
        .fv_rst(fv_rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every err_valid strobe must match the oldest expected error.
    always @(negedge clk) begin
        if (!fv_rst && bus.err_valid) begin
            if (sb.size() == 0)
                check("ev_unexpected", 32'd1, 32'd0);
            else
                check("phase_err", {24'd0, bus.phase_err}, {24'd0, sb.pop_front()});
        end
    end

    // One measurement: leader rises now, lagger gap cycles later.
    task automatic run_meas(input bit lead_link, input int gap, input logic [7:0] exp);
        sb.push_back(exp);
        if (lead_link) bus.link = 1'b1; else bus.vco = 1'b1;
        tick(gap);
        bus.link = 1'b1;
        bus.vco  = 1'b1;
        tick(8);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(4);
    endtask

    initial begin
        bus.en   = 1'b1;
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(3);
        check("rst_up",      {31'd0, bus.up},        32'd0);
        check("rst_dn",      {31'd0, bus.dn},        32'd0);
        check("rst_upb",     {31'd0, bus.upb},       32'd1);
        check("rst_dnb",     {31'd0, bus.dnb},       32'd1);
        check("rst_setting", {30'd0, bus.setting},   32'd0);
        check("rst_phase",   {24'd0, bus.phase_err}, 32'd0);
        check("rst_ev",      {31'd0, bus.err_valid}, 32'd0);
        check("rst_slip",    {31'd0, bus.slip},      32'd0);
        check("rst_lock",    {31'd0, bus.lock},      32'd0);
        fv_rst = 1'b0;
        tick(4);

        // Link leads by 3: edge at n+2, up high n+3..n+5, err_valid n+6.
        sb.push_back(8'd3);
        bus.link = 1'b1;
        tick(2);
        check("A_up_early", {31'd0, bus.up}, 32'd0);
        tick(1);
        check("A_up_rise", {31'd0, bus.up}, 32'd1);
        bus.vco = 1'b1;
        tick(2);
        check("A_up_last", {31'd0, bus.up}, 32'd1);
        check("A_setting", {30'd0, bus.setting}, 32'd1);
        tick(1);
        check("A_up_fall", {31'd0, bus.up}, 32'd0);
        check("A_ev", {31'd0, bus.err_valid}, 32'd1);
        tick(6);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(5);

        // VCO leads by 1: dn stretched to MIN_PW, phase -1.
        sb.push_back(8'hFF);
        bus.vco = 1'b1;
        tick(1);
        bus.link = 1'b1;
        tick(2);
        check("B_dn1", {31'd0, bus.dn}, 32'd1);
        check("B_setting", {30'd0, bus.setting}, 32'd3);
        tick(1);
        check("B_dn2", {31'd0, bus.dn}, 32'd1);
        check("B_ev", {31'd0, bus.err_valid}, 32'd1);
        check("B_up", {31'd0, bus.up}, 32'd0);
        tick(1);
        check("B_dn_off", {31'd0, bus.dn}, 32'd0);
        tick(5);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(5);

        // Coincident edges: phase 0, both pumps for exactly 2 cycles.
        sb.push_back(8'd0);
        bus.link = 1'b1;
        bus.vco  = 1'b1;
        tick(3);
        check("C_setting", {30'd0, bus.setting}, 32'd3);
        check("C_ev", {31'd0, bus.err_valid}, 32'd1);
        tick(1);
        check("C_both2", {30'd0, bus.up, bus.dn}, 32'd3);
        check("C_ev_once", {31'd0, bus.err_valid}, 32'd0);
        tick(1);
        check("C_both_off", {30'd0, bus.up, bus.dn}, 32'd0);
        tick(5);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(5);

        // Slip: second link edge 10 cycles later, vco very late -> saturation.
        bus.link = 1'b1;
        tick(3);
        bus.link = 1'b0;
        tick(7);
        bus.link = 1'b1;
        tick(2);
        check("D_slip_pre", {31'd0, bus.slip}, 32'd0);
        tick(1);
        check("D_slip", {31'd0, bus.slip}, 32'd1);
        tick(1);
        check("D_slip_once", {31'd0, bus.slip}, 32'd0);
        tick(286);
        sb.push_back(8'd127);
        bus.vco = 1'b1;
        tick(10);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(5);

        // Lock after four +1 measurements, dropped by a +3.
        for (int i = 0; i < 3; i++) begin
            run_meas(1'b1, 1, 8'd1);
            check("E_lock_pre", {31'd0, bus.lock}, 32'd0);
        end
        sb.push_back(8'd1);
        bus.link = 1'b1;
        tick(1);
        bus.vco = 1'b1;
        tick(3);
        check("E_ev4", {31'd0, bus.err_valid}, 32'd1);
        check("E_lock_at_ev", {31'd0, bus.lock}, 32'd0);
        tick(1);
        check("E_lock_on", {31'd0, bus.lock}, 32'd1);
        tick(5);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(4);
        sb.push_back(8'd3);
        bus.link = 1'b1;
        tick(3);
        bus.vco = 1'b1;
        tick(3);
        check("E_ev_bad", {31'd0, bus.err_valid}, 32'd1);
        check("E_lock_hold", {31'd0, bus.lock}, 32'd1);
        tick(1);
        check("E_lock_drop", {31'd0, bus.lock}, 32'd0);
        tick(5);
        bus.link = 1'b0;
        bus.vco  = 1'b0;
        tick(4);

        // Relock, then asynchronous reset in the middle of an UP_RUN.
        for (int i = 0; i < 4; i++) run_meas(1'b1, 1, 8'd1);
        check("F_lock", {31'd0, bus.lock}, 32'd1);
        bus.link = 1'b1;
        tick(4);
        check("F_up_run", {31'd0, bus.up}, 32'd1);
        #2 fv_rst = 1'b1;
        #1;
        check("F_rst_up",   {31'd0, bus.up},   32'd0);
        check("F_rst_upb",  {31'd0, bus.upb},  32'd1);
        check("F_rst_lock", {31'd0, bus.lock}, 32'd0);
        bus.link = 1'b0;
        tick(2);
        fv_rst = 1'b0;
        tick(3);
        bus.vco = 1'b1;
        tick(20);
        bus.vco = 1'b0;
        tick(5);

        check("sb_left", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
